// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Two requesters share one byte-wide UART transmitter. Each requester offers
//   a 12-bit pixel {R[3:0],G[3:0],B[3:0]}. A round-robin arbiter picks one
//   requester while idle, latches its pixel and streams it to the transmitter
//   as the bytes {R,4'h0}, {G,4'h0}, {B,4'h0}. Each byte goes through a
//   start / wait-for-busy / wait-for-free handshake. After a packet the
//   arbiter holds off for IDLE_GAP cycles before it grants again.
//
// Optional feature:
//   UART_TX_CHECKSUM_EN  when defined, a fourth byte {R^G^B,4'h0} follows the
//                        B byte, and done pulses after that byte.
//
// Parameters:
//   IDLE_GAP   idle cycles after each packet, 0..15 (default 2)
//
// Ports:
//   clock     in   1   system clock, all state changes on posedge
//   reset     in   1   synchronous, active-high reset
//   req       in   2   per-requester packet request (level, held until grant)
//   data0     in  12   requester 0 pixel
//   data1     in  12   requester 1 pixel
//   grant     out  2   one-hot pulse in LOAD: packet of that requester latched
//   tx_start  out  1   pulse to transmitter: send tx_data
//   tx_data   out  8   byte to transmitter
//   tx_busy   in   1   transmitter busy
//   done      out  2   one-hot pulse in DONE: packet of that requester sent
//   busy      out  1   high whenever the FSM is not in IDLE
//   stateID   out  3   current state encoding
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int IDLE_GAP = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [11:0] data0,
  input  logic [11:0] data1,
  output logic [1:0]  grant,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [1:0]  done,
  output logic        busy,
  output logic [2:0]  stateID
);

`ifdef UART_TX_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd3;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

  // Gap counter runs 0..IDLE_GAP-1 while in GAP.
  localparam logic [3:0] GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_FREE = 3'd4,
    DONE      = 3'd5,
    GAP       = 3'd6
  } state_t;

  state_t      state_reg, state_next;
  logic        winner_reg, winner_next;
  logic        last_reg, last_next;
  logic [11:0] pixel_reg, pixel_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic        pick;

  // Round-robin choice: on a tie the requester not granted last time wins;
  // otherwise the single active requester wins.
  always_comb begin
    if (req == 2'b11) begin
      pick = ~last_reg;
    end else begin
      pick = req[1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      winner_reg   <= 1'b0;
      last_reg     <= 1'b1;   // requester 0 wins the first tie
      pixel_reg    <= 12'h000;
      byte_idx_reg <= 2'd0;
      gap_cnt_reg  <= 4'd0;
    end else begin
      state_reg    <= state_next;
      winner_reg   <= winner_next;
      last_reg     <= last_next;
      pixel_reg    <= pixel_next;
      byte_idx_reg <= byte_idx_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    winner_next   = winner_reg;
    last_next     = last_reg;
    pixel_next    = pixel_reg;
    byte_idx_next = byte_idx_reg;
    gap_cnt_next  = gap_cnt_reg;
    tx_start      = 1'b0;

    case (state_reg)
      IDLE: begin
        // req and data are only looked at here; later changes are ignored.
        if (req != 2'b00) begin
          winner_next = pick;
          last_next   = pick;
          pixel_next  = pick ? data1 : data0;
          state_next  = LOAD;
        end
      end
      LOAD: begin
        byte_idx_next = 2'd0;
        state_next    = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_FREE;
        end
      end
      WAIT_FREE: begin
        if (!tx_busy) begin
          byte_idx_next = byte_idx_reg + 2'd1;
          state_next    = (byte_idx_reg == LAST_BYTE) ? DONE : SEND;
        end
      end
      DONE: begin
        if (IDLE_GAP > 0) begin
          gap_cnt_next = 4'd0;
          state_next   = GAP;
        end else begin
          state_next = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte selection: the pixel and index only change in IDLE/LOAD and on
  // leaving WAIT_FREE, so tx_data is steady across each byte's handshake.
  always_comb begin
    case (byte_idx_reg)
      2'd0:    tx_data = {pixel_reg[11:8], 4'h0};
      2'd1:    tx_data = {pixel_reg[7:4], 4'h0};
      2'd2:    tx_data = {pixel_reg[3:0], 4'h0};
`ifdef UART_TX_CHECKSUM_EN
      default: tx_data = {pixel_reg[11:8] ^ pixel_reg[7:4] ^ pixel_reg[3:0], 4'h0};
`else
      default: tx_data = 8'h00;
`endif
    endcase
  end

  // One-hot grant/done decode for the latched winner.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_onehot
      assign grant[gi] = (state_reg == LOAD) && (winner_reg == 1'(gi));
      assign done[gi]  = (state_reg == DONE) && (winner_reg == 1'(gi));
    end
  endgenerate

  assign busy    = (state_reg != IDLE);
  assign stateID = state_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

`ifdef UART_TX_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [11:0] data0 = 12'h000;
  logic [11:0] data1 = 12'h000;
  logic [1:0]  grant, done;
  logic        tx_start, busy;
  logic [7:0]  tx_data;
  logic [2:0]  stateID;
  logic        tx_busy;

  // Transmitter model: busy rises the cycle after a start and stays high
  // for busy_len cycles. tx_auto=0 hands tx_busy to the bench directly.
  logic tx_auto = 1'b1;
  logic manual_busy = 1'b0;
  logic model_busy = 1'b0;
  logic start_seen = 1'b0;
  int   bcnt = 0;
  int   busy_len = 10;
  assign tx_busy = tx_auto ? model_busy : manual_busy;

  // Second instance with IDLE_GAP=0 and a minimal transmitter.
  logic [1:0] req_g0 = 2'b00;
  logic [1:0] grant_g0, done_g0;
  logic       tx_start_g0, busy_g0, tx_busy_g0;
  logic [7:0] tx_data_g0;
  logic [2:0] stateID_g0;

  int checks = 0;
  int fails = 0;
  int last_m = 1;
  logic [7:0] seen_q[$];

  uart_tx_arbiter #(.IDLE_GAP(3)) dut (
    .clock(clock), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .grant(grant), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .done(done), .busy(busy), .stateID(stateID)
  );

  uart_tx_arbiter #(.IDLE_GAP(0)) dut_g0 (
    .clock(clock), .reset(reset), .req(req_g0), .data0(data0), .data1(data1),
    .grant(grant_g0), .tx_start(tx_start_g0), .tx_data(tx_data_g0), .tx_busy(tx_busy_g0),
    .done(done_g0), .busy(busy_g0), .stateID(stateID_g0)
  );

  always #5 clock = ~clock;

  always @(negedge clock) start_seen = tx_start;

  always @(posedge clock) begin
    #1;
    if (reset || !tx_auto) begin
      bcnt = 0;
      model_busy = 1'b0;
    end else if (bcnt > 0) begin
      bcnt = bcnt - 1;
      model_busy = (bcnt != 0);
    end else if (start_seen) begin
      bcnt = busy_len;
      model_busy = 1'b1;
    end
  end

  initial tx_busy_g0 = 1'b0;
  always @(posedge clock) tx_busy_g0 <= tx_start_g0;

  // Reference: packet bytes from the pixel, and round-robin winner choice.
  function automatic logic [7:0] exp_byte(input logic [11:0] d, input int i);
    logic [3:0] r, g, b;
    r = d[11:8]; g = d[7:4]; b = d[3:0];
    case (i)
      0:       return {r, 4'h0};
      1:       return {g, 4'h0};
      2:       return {b, 4'h0};
      default: return {r ^ g ^ b, 4'h0};
    endcase
  endfunction

  function automatic int pick_winner(input logic [1:0] r);
    int w;
    if (r == 2'b11) w = (last_m == 1) ? 0 : 1;
    else            w = r[1] ? 1 : 0;
    last_m = w;
    return w;
  endfunction

  // Wait (bounded) for a grant pulse; returns 0 on timeout.
  task automatic wait_grant(output logic [1:0] g);
    int n;
    n = 0;
    @(negedge clock);
    while (grant == 2'b00 && n < 300) begin
      @(negedge clock);
      n++;
    end
    g = grant;
  endtask

  // Record started bytes until done (bounded); report extra grants and
  // tx_data changes while a byte is in flight.
  task automatic collect(input logic [7:0] cur0, output logic [1:0] dn,
                         output int extra_g, output int unstable);
    logic [7:0] cur;
    int n;
    cur = cur0; dn = 2'b00; extra_g = 0; unstable = 0; n = 0;
    while (n < 3000) begin
      @(negedge clock);
      n++;
      if (grant != 2'b00) extra_g++;
      if (tx_start) begin
        seen_q.push_back(tx_data);
        cur = tx_data;
      end else if ((stateID == 3'd3 || stateID == 3'd4) && tx_data != cur) begin
        unstable++;
      end
      if (done != 2'b00) begin
        dn = done;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; req_g0 = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    last_m = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (grant !== 2'b00)    begin fails++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++; if (tx_start !== 1'b0)  begin fails++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00)  begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (done !== 2'b00)     begin fails++; $display("FAIL reset_done got %b want 00", done); end
    checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (stateID !== 3'd0)   begin fails++; $display("FAIL reset_state got %0d want 0", stateID); end
    repeat (5) @(negedge clock);
    checks++; if (stateID !== 3'd0)   begin fails++; $display("FAIL idle_hold state got %0d want 0", stateID); end
    $display("reset: state=%0d busy=%b", stateID, busy);
  endtask

  task automatic test_basic();
    logic [1:0] g, dn;
    int eg, us, w;
    busy_len = 10;
    data0 = 12'hF3A; data1 = 12'($urandom); req = 2'b01;
    w = pick_winner(2'b01);
    wait_grant(g);
    req = 2'b00;
    checks++; if (g !== 2'b01) begin fails++; $display("FAIL basic_grant got %b want 01", g); end
    seen_q.delete();
    collect(8'h00, dn, eg, us);
    checks++; if (seen_q.size() != NB) begin fails++; $display("FAIL basic_count got %0d want %0d", seen_q.size(), NB); end
    for (int i = 0; i < NB && i < seen_q.size(); i++) begin
      checks++;
      if (seen_q[i] !== exp_byte(12'hF3A, i)) begin
        fails++; $display("FAIL basic_byte%0d got %h want %h", i, seen_q[i], exp_byte(12'hF3A, i));
      end
    end
    checks++; if (dn !== 2'b01) begin fails++; $display("FAIL basic_done got %b want 01", dn); end
    checks++; if (eg != 0)      begin fails++; $display("FAIL basic_extra_grant got %0d want 0", eg); end
    checks++; if (us != 0)      begin fails++; $display("FAIL basic_tx_data_stable got %0d changes want 0", us); end
    $display("basic: winner=%0d grant=%b bytes=%0d done=%b", w, g, seen_q.size(), dn);
  endtask

  task automatic test_round_robin();
    logic [1:0] g, dn, eg2;
    logic [11:0] d0, d1, ds;
    int eg, us, w;
    do_reset();
    d0 = 12'($urandom); d1 = 12'($urandom);
    data0 = d0; data1 = d1; req = 2'b11;
    for (int p = 0; p < 3; p++) begin
      w = pick_winner(2'b11);
      eg2 = (w == 1) ? 2'b10 : 2'b01;
      ds = (w == 1) ? d1 : d0;
      wait_grant(g);
      checks++; if (g !== eg2) begin fails++; $display("FAIL rr_grant%0d got %b want %b", p, g, eg2); end
      seen_q.delete();
      collect(8'h00, dn, eg, us);
      checks++; if (seen_q.size() != NB) begin fails++; $display("FAIL rr_count%0d got %0d want %0d", p, seen_q.size(), NB); end
      for (int i = 0; i < NB && i < seen_q.size(); i++) begin
        checks++;
        if (seen_q[i] !== exp_byte(ds, i)) begin
          fails++; $display("FAIL rr_byte%0d_%0d got %h want %h", p, i, seen_q[i], exp_byte(ds, i));
        end
      end
      checks++; if (dn !== eg2) begin fails++; $display("FAIL rr_done%0d got %b want %b", p, dn, eg2); end
      $display("rr: packet=%0d grant=%b done=%b", p, g, dn);
    end
    req = 2'b00;
  endtask

  task automatic test_busy_hold();
    logic [1:0] g, dn;
    logic [11:0] d;
    logic [7:0] b0;
    int eg, us, w, nstart, nsend;
    d = 12'($urandom);
    tx_auto = 1'b0; manual_busy = 1'b0;
    data0 = d; req = 2'b01;
    w = pick_winner(2'b01);
    wait_grant(g);
    req = 2'b00; manual_busy = 1'b1;
    checks++; if (g !== 2'b01) begin fails++; $display("FAIL hold_grant got %b want 01", g); end
    nstart = 0; nsend = 0;
    repeat (20) begin
      @(negedge clock);
      if (tx_start) nstart++;
      if (stateID == 3'd2) nsend++;
    end
    checks++; if (nstart != 0)  begin fails++; $display("FAIL hold_no_start got %0d starts want 0", nstart); end
    checks++; if (nsend != 20)  begin fails++; $display("FAIL hold_in_send got %0d cycles want 20", nsend); end
    @(posedge clock); #1;
    manual_busy = 1'b0;
    @(negedge clock);
    checks++; if (tx_start !== 1'b1) begin fails++; $display("FAIL hold_start_after_free got %b want 1", tx_start); end
    checks++; if (tx_data !== exp_byte(d, 0)) begin fails++; $display("FAIL hold_byte0 got %h want %h", tx_data, exp_byte(d, 0)); end
    b0 = tx_data;
    tx_auto = 1'b1;
    seen_q.delete();
    collect(b0, dn, eg, us);
    checks++; if (seen_q.size() != NB - 1) begin fails++; $display("FAIL hold_count got %0d want %0d", seen_q.size(), NB - 1); end
    for (int i = 0; i < NB - 1 && i < seen_q.size(); i++) begin
      checks++;
      if (seen_q[i] !== exp_byte(d, i + 1)) begin
        fails++; $display("FAIL hold_byte%0d got %h want %h", i + 1, seen_q[i], exp_byte(d, i + 1));
      end
    end
    checks++; if (dn !== 2'b01) begin fails++; $display("FAIL hold_done got %b want 01", dn); end
    $display("busy_hold: starts_during_busy=%0d done=%b", nstart, dn);
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    int w, ns, n, ndone;
    data0 = 12'($urandom); req = 2'b01;
    w = pick_winner(2'b01);
    wait_grant(g);
    req = 2'b00;
    checks++; if (g !== 2'b01) begin fails++; $display("FAIL rmid_grant got %b want 01", g); end
    ns = 0; n = 0;
    if (tx_start) ns++;
    while (n < 500 && !(ns == 2 && stateID == 3'd4)) begin
      @(negedge clock);
      n++;
      if (tx_start) ns++;
    end
    checks++; if (!(ns == 2 && stateID == 3'd4)) begin fails++; $display("FAIL rmid_reach_g_wait_free got starts=%0d state=%0d want 2/4", ns, stateID); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (stateID !== 3'd0)  begin fails++; $display("FAIL rmid_state got %0d want 0", stateID); end
    checks++; if (busy !== 1'b0)     begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rmid_tx_start got %b want 0", tx_start); end
    reset = 1'b0;
    last_m = 1;
    ndone = 0;
    if (done != 2'b00) ndone++;
    repeat (30) begin
      @(negedge clock);
      if (done != 2'b00) ndone++;
    end
    checks++; if (ndone != 0) begin fails++; $display("FAIL rmid_no_done got %0d pulses want 0", ndone); end
    $display("reset_mid: state=%0d done_pulses=%0d", stateID, ndone);
  endtask

  task automatic test_gap();
    logic [1:0] g, dn;
    int eg, us, w, ngap, n, ng0;
    data0 = 12'($urandom); req = 2'b01;
    w = pick_winner(2'b01);
    wait_grant(g);
    checks++; if (g !== 2'b01) begin fails++; $display("FAIL gap_grant1 got %b want 01", g); end
    seen_q.delete();
    collect(8'h00, dn, eg, us);
    checks++; if (dn !== 2'b01) begin fails++; $display("FAIL gap_done1 got %b want 01", dn); end
    ngap = 0; n = 0;
    while (grant == 2'b00 && n < 200) begin
      @(negedge clock);
      n++;
      if (stateID == 3'd6) ngap++;
    end
    w = pick_winner(2'b01);
    req = 2'b00;
    checks++; if (grant !== 2'b01) begin fails++; $display("FAIL gap_grant2 got %b want 01", grant); end
    checks++; if (ngap != 3) begin fails++; $display("FAIL gap_cycles got %0d want 3", ngap); end
    seen_q.delete();
    collect(8'h00, dn, eg, us);
    checks++; if (dn !== 2'b01) begin fails++; $display("FAIL gap_done2 got %b want 01", dn); end
    $display("gap3: gap_cycles=%0d", ngap);

    req_g0 = 2'b01; n = 0; ng0 = 0;
    while (done_g0 == 2'b00 && n < 300) begin
      @(negedge clock);
      n++;
      if (grant_g0 != 2'b00) begin ng0++; req_g0 = 2'b00; end
    end
    req_g0 = 2'b00;
    checks++; if (done_g0 !== 2'b01) begin fails++; $display("FAIL gap0_done got %b want 01", done_g0); end
    checks++; if (ng0 != 1) begin fails++; $display("FAIL gap0_grants got %0d want 1", ng0); end
    @(negedge clock);
    checks++; if (stateID_g0 !== 3'd0) begin fails++; $display("FAIL gap0_done_to_idle got state %0d want 0", stateID_g0); end
    $display("gap0: state_after_done=%0d", stateID_g0);
  endtask

  task automatic test_withdrawn();
    logic [1:0] g, dn;
    int eg, us, w, ng;
    data0 = 12'($urandom); req = 2'b01;
    w = pick_winner(2'b01);
    wait_grant(g);
    req = 2'b00;
    checks++; if (g !== 2'b01) begin fails++; $display("FAIL wd_grant got %b want 01", g); end
    repeat (3) @(negedge clock);
    req = 2'b10;
    @(negedge clock);
    req = 2'b00;
    seen_q.delete();
    collect(8'h00, dn, eg, us);
    checks++; if (dn !== 2'b01) begin fails++; $display("FAIL wd_done got %b want 01", dn); end
    ng = eg;
    repeat (40) begin
      @(negedge clock);
      if (grant != 2'b00) ng++;
    end
    checks++; if (ng != 0) begin fails++; $display("FAIL wd_never_granted got %0d grants want 0", ng); end
    $display("withdrawn: stray_grants=%0d", ng);
  endtask

  task automatic test_random();
    logic [1:0] r, g, dn, eg2;
    logic [11:0] d0, d1, ds;
    int eg, us, w;
    for (int p = 0; p < 12; p++) begin
      r = 2'($urandom_range(1, 3));
      d0 = 12'($urandom); d1 = 12'($urandom);
      busy_len = int'($urandom_range(1, 12));
      data0 = d0; data1 = d1; req = r;
      w = pick_winner(r);
      eg2 = (w == 1) ? 2'b10 : 2'b01;
      ds = (w == 1) ? d1 : d0;
      wait_grant(g);
      req = 2'b00;
      data0 = 12'($urandom); data1 = 12'($urandom);
      checks++; if (g !== eg2) begin fails++; $display("FAIL rnd_grant%0d got %b want %b", p, g, eg2); end
      seen_q.delete();
      collect(8'h00, dn, eg, us);
      checks++; if (seen_q.size() != NB) begin fails++; $display("FAIL rnd_count%0d got %0d want %0d", p, seen_q.size(), NB); end
      for (int i = 0; i < NB && i < seen_q.size(); i++) begin
        checks++;
        if (seen_q[i] !== exp_byte(ds, i)) begin
          fails++; $display("FAIL rnd_byte%0d_%0d got %h want %h", p, i, seen_q[i], exp_byte(ds, i));
        end
      end
      checks++; if (dn !== eg2) begin fails++; $display("FAIL rnd_done%0d got %b want %b", p, dn, eg2); end
      checks++; if (eg != 0 || us != 0) begin fails++; $display("FAIL rnd_clean%0d got extra_grants=%0d data_changes=%0d want 0/0", p, eg, us); end
      $display("rnd: packet=%0d req=%b pixel=%h grant=%b bytes=%0d done=%b", p, r, ds, g, seen_q.size(), dn);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_busy_hold();
    test_reset_mid();
    test_gap();
    test_withdrawn();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before completion (compared=%0d)", checks);
    $fatal(1, "watchdog");
  end

endmodule
